// File: rtl/flow_stage_sequencer.sv
// Valve sequencer for the seven-row chamber/mixer dilution tree: opens one row's valve
// group per stage for its dwell, then closes all valves for SETTLE_CYCLES. Optional hold: FLOW_SEQ_PAUSE_EN.
module flow_stage_sequencer #(
    parameter int STAGES        = 7,
    parameter int DWELL_W       = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int DEFAULT_DWELL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               hold,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [DWELL_W-1:0] cfg_data,
    output logic               cfg_rej,
    output logic [STAGES-1:0]  valve_en,
    output logic               pump_en,
    output logic [2:0]         stage_idx,
    output logic               busy,
    output logic               done,
    output logic               aborted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        SETTLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [STAGES-1:0] VALVE_ONE = {{(STAGES-1){1'b0}}, 1'b1};

    state_t             state, state_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [2:0]         stage_d;
    logic [DWELL_W-1:0] dwell [STAGES];

    logic               first_found, next_found;
    logic [2:0]         first_idx, next_idx;
    logic               hold_req, freeze;
    logic               cfg_ok;
    logic [STAGES-1:0]  valve_d;
    logic               busy_d, done_d, aborted_d, cfg_rej_d;

`ifdef FLOW_SEQ_PAUSE_EN
    assign hold_req = hold;
`else
    logic unused_hold;
    assign unused_hold = hold;
    assign hold_req    = 1'b0;
`endif

    // Handshake: start is a level sampled only in IDLE; abort wins over start and hold;
    // done/aborted/cfg_rej are single-cycle pulses, busy covers OPEN and SETTLE only.
    assign freeze = hold_req && !abort && (state == OPEN || state == SETTLE);
    assign cfg_ok = cfg_we && (state == IDLE) && ({29'b0, cfg_addr} < 32'(STAGES));

    // Zero-dwell stages are skipped by searching for the next nonzero dwell.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (!first_found && dwell[i] != '0) begin
                first_found = 1'b1;
                first_idx   = 3'(i);
            end
            if (!next_found && i > int'(stage_idx) && dwell[i] != '0) begin
                next_found = 1'b1;
                next_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        stage_d   = stage_idx;
        aborted_d = 1'b0;
        cfg_rej_d = cfg_we && !cfg_ok;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (first_found) begin
                        state_d = OPEN;
                        stage_d = first_idx;
                        cnt_d   = dwell[first_idx];
                    end else begin
                        state_d = FINISH;
                        stage_d = '0;
                    end
                end
            end
            OPEN: begin
                if (abort) begin
                    state_d   = IDLE;
                    stage_d   = '0;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end else if (!freeze) begin
                    if (cnt == DWELL_W'(1)) begin
                        state_d = SETTLE;
                        cnt_d   = DWELL_W'(SETTLE_CYCLES);
                    end else begin
                        cnt_d = cnt - DWELL_W'(1);
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d   = IDLE;
                    stage_d   = '0;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end else if (!freeze) begin
                    if (cnt == DWELL_W'(1)) begin
                        if (int'(stage_idx) == STAGES - 1 || !next_found) begin
                            state_d = FINISH;
                            cnt_d   = '0;
                        end else begin
                            state_d = OPEN;
                            stage_d = next_idx;
                            cnt_d   = dwell[next_idx];
                        end
                    end else begin
                        cnt_d = cnt - DWELL_W'(1);
                    end
                end
            end
            FINISH: begin
                state_d   = IDLE;
                stage_d   = '0;
                aborted_d = abort;
            end
            default: begin
                state_d = IDLE;
                stage_d = '0;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register on the same edge.
        busy_d  = (state_d == OPEN) || (state_d == SETTLE);
        done_d  = (state_d == FINISH);
        valve_d = (state_d == OPEN && !freeze) ? (VALVE_ONE << stage_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            stage_idx <= '0;
            valve_en  <= '0;
            pump_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_rej   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            stage_idx <= stage_d;
            valve_en  <= valve_d;
            pump_en   <= busy_d;
            busy      <= busy_d;
            done      <= done_d;
            aborted   <= aborted_d;
            cfg_rej   <= cfg_rej_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                dwell[i] <= DWELL_W'(DEFAULT_DWELL);
            end
        end else if (cfg_ok) begin
            dwell[cfg_addr] <= cfg_data;
        end
    end

endmodule
